regfile_mbist_ctrl: RTL and testbench

//  March C- memory-BIST controller for the integer/FP register file BIST collar.

---
 rtl/regfile_mbist_ctrl.sv | 229 ++++++++++++++++++++++
 tb/tb_regfile_mbist_ctrl.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mbist_ctrl.sv
// March C- memory-BIST controller for the register-file test collar.
// Drives the wrapper's BIST/CSN_T/WEN_T/A_T/D_T ports and checks Q_T one cycle
// after each read. Address 0 is never exercised (it is not writable).
// Optional feature: define REGFILE_MBIST_DIAG_EN to build first-fail diagnostic
// registers (address, read data, march element); otherwise those outputs are 0.
module regfile_mbist_ctrl #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int FIRST_ADDR = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    output logic                  bist_o,
    output logic                  csn_t_o,
    output logic                  wen_t_o,
    output logic [ADDR_WIDTH-1:0] a_t_o,
    output logic [DATA_WIDTH-1:0] d_t_o,
    input  logic [DATA_WIDTH-1:0] q_t_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  fail_o,
    output logic [ADDR_WIDTH-1:0] fail_addr_o,
    output logic [DATA_WIDTH-1:0] fail_data_o,
    output logic [2:0]            fail_elem_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_RD,
        S_RDONLY,
        S_DRAIN,
        S_DONE
    } state_e;

    localparam logic [ADDR_WIDTH-1:0] MIN_ADDR  = ADDR_WIDTH'(FIRST_ADDR);
    localparam logic [ADDR_WIDTH-1:0] MAX_ADDR  = '1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
    localparam logic [2:0]            LAST_ELEM = 3'd5;

    // E3 and E4 walk the address space downwards; all other elements go up.
    function automatic logic elem_down(input logic [2:0] e);
        return (e == 3'd3) || (e == 3'd4);
    endfunction

    // E1 and E3 write the all-ones word; E0, E2, E4 write all-zeros.
    function automatic logic wr_ones(input logic [2:0] e);
        return (e == 3'd1) || (e == 3'd3);
    endfunction

    // E2 and E4 expect to read back all-ones; E1, E3, E5 expect all-zeros.
    function automatic logic rd_ones(input logic [2:0] e);
        return (e == 3'd2) || (e == 3'd4);
    endfunction

    state_e                  state_q, state_d;
    logic [2:0]              elem_q, elem_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    cmp_valid_q, cmp_valid_d;
    logic [DATA_WIDTH-1:0]   cmp_exp_q, cmp_exp_d;
    logic                    fail_q, fail_d;

    logic                    last_addr;
    logic [2:0]              next_elem;
    logic                    start_accept;
    logic                    mismatch;

    assign last_addr    = elem_down(elem_q) ? (addr_q == MIN_ADDR) : (addr_q == MAX_ADDR);
    assign next_elem    = elem_q + 3'd1;
    assign start_accept = start_i && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign mismatch     = cmp_valid_q && (q_t_i != cmp_exp_q);

    // State register: sequencer state, march element and current address.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            elem_q  <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            elem_q  <= elem_d;
            addr_q  <= addr_d;
        end
    end

    // Next-state logic: walk each element's addresses, chaining elements back to back.
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        elem_d  = elem_q;
        addr_d  = addr_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    state_d = S_WR;
                    elem_d  = '0;
                    addr_d  = MIN_ADDR;
                end
            end
            S_WR: begin
                if (last_addr) begin
                    elem_d  = next_elem;
                    addr_d  = elem_down(next_elem) ? MAX_ADDR : MIN_ADDR;
                    state_d = (next_elem == LAST_ELEM) ? S_RDONLY : S_RD;
                end else begin
                    addr_d  = elem_down(elem_q) ? (addr_q - ADDR_ONE) : (addr_q + ADDR_ONE);
                    state_d = (elem_q == 3'd0) ? S_WR : S_RD;
                end
            end
            S_RD: begin
                state_d = S_WR;
            end
            S_RDONLY: begin
                if (last_addr) begin
                    state_d = S_DRAIN;
                end else begin
                    addr_d = addr_q + ADDR_ONE;
                end
            end
            S_DRAIN: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output logic: one wrapper operation per cycle, decoded from the current state.
    always_comb begin
        csn_t_o = 1'b1;
        wen_t_o = 1'b1;
        a_t_o   = '0;
        d_t_o   = '0;
        unique case (state_q)
            S_WR: begin
                csn_t_o = 1'b0;
                wen_t_o = 1'b0;
                a_t_o   = addr_q;
                d_t_o   = wr_ones(elem_q) ? '1 : '0;
            end
            S_RD, S_RDONLY: begin
                csn_t_o = 1'b0;
                a_t_o   = addr_q;
            end
            default: begin
            end
        endcase
    end

    assign bist_o = (state_q != S_IDLE) && (state_q != S_DONE);
    assign busy_o = bist_o;
    assign done_o = (state_q == S_DONE);
    assign fail_o = fail_q;

    // Compare pipeline and sticky fail: a read issued now is checked against Q_T next cycle.
    always_comb begin
        cmp_valid_d = (state_q == S_RD) || (state_q == S_RDONLY);
        cmp_exp_d   = rd_ones(elem_q) ? '1 : '0;
        fail_d      = start_accept ? 1'b0 : (fail_q | mismatch);
    end

    // Compare pipeline and fail flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmp_valid_q <= 1'b0;
            cmp_exp_q   <= '0;
            fail_q      <= 1'b0;
        end else begin
            cmp_valid_q <= cmp_valid_d;
            cmp_exp_q   <= cmp_exp_d;
            fail_q      <= fail_d;
        end
    end

`ifdef REGFILE_MBIST_DIAG_EN
    logic [ADDR_WIDTH-1:0] cmp_addr_q, cmp_addr_d;
    logic [2:0]            cmp_elem_q, cmp_elem_d;
    logic [ADDR_WIDTH-1:0] diag_addr_q, diag_addr_d;
    logic [DATA_WIDTH-1:0] diag_data_q, diag_data_d;
    logic [2:0]            diag_elem_q, diag_elem_d;

    // Diagnostic capture: latch the first mismatch only, clear on an accepted start.
    always_comb begin
        cmp_addr_d  = addr_q;
        cmp_elem_d  = elem_q;
        diag_addr_d = diag_addr_q;
        diag_data_d = diag_data_q;
        diag_elem_d = diag_elem_q;
        if (start_accept) begin
            diag_addr_d = '0;
            diag_data_d = '0;
            diag_elem_d = '0;
        end else if (mismatch && !fail_q) begin
            diag_addr_d = cmp_addr_q;
            diag_data_d = q_t_i;
            diag_elem_d = cmp_elem_q;
        end
    end

    // Diagnostic registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmp_addr_q  <= '0;
            cmp_elem_q  <= '0;
            diag_addr_q <= '0;
            diag_data_q <= '0;
            diag_elem_q <= '0;
        end else begin
            cmp_addr_q  <= cmp_addr_d;
            cmp_elem_q  <= cmp_elem_d;
            diag_addr_q <= diag_addr_d;
            diag_data_q <= diag_data_d;
            diag_elem_q <= diag_elem_d;
        end
    end

    assign fail_addr_o = diag_addr_q;
    assign fail_data_o = diag_data_q;
    assign fail_elem_o = diag_elem_q;
`else
    assign fail_addr_o = '0;
    assign fail_data_o = '0;
    assign fail_elem_o = '0;
`endif

endmodule

// File: tb/tb_regfile_mbist_ctrl.sv
// Self-checking bench for regfile_mbist_ctrl (AW=5, DW=32).
// Contains a behavioural register-file/wrapper model with stuck-at fault
// injection on read data, and a reference model that lists the March C-
// operation sequence and predicts the fail flag and first-fail diagnostics.
module tb_regfile_mbist_ctrl;

    localparam int AW       = 5;
    localparam int DW       = 32;
    localparam int FIRST    = 1;
    localparam int MAXA     = (1 << AW) - 1;
    localparam int N        = MAXA - FIRST + 1;
    localparam int BUSY_LEN = 10 * N + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start_i = 1'b0;
    logic          bist_o, csn_t_o, wen_t_o, busy_o, done_o, fail_o;
    logic [AW-1:0] a_t_o, fail_addr_o;
    logic [DW-1:0] d_t_o, q_t_i, fail_data_o;
    logic [2:0]    fail_elem_o;

    always #5 clk = ~clk;

    regfile_mbist_ctrl #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .FIRST_ADDR (FIRST)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start_i),
        .bist_o      (bist_o),
        .csn_t_o     (csn_t_o),
        .wen_t_o     (wen_t_o),
        .a_t_o       (a_t_o),
        .d_t_o       (d_t_o),
        .q_t_i       (q_t_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .fail_o      (fail_o),
        .fail_addr_o (fail_addr_o),
        .fail_data_o (fail_data_o),
        .fail_elem_o (fail_elem_o)
    );

    // ---------------- register file + wrapper model ----------------
    bit            fault_en   = 1'b0;
    int            fault_addr = 0;
    logic [DW-1:0] fault_mask = '0;
    bit            fault_sa1  = 1'b0;
    logic [DW-1:0] reg0_val   = '0;   // content of the non-writable register 0

    logic [DW-1:0] rf_mem [0:MAXA];
    logic [DW-1:0] rf_q = '0;

    function automatic logic [DW-1:0] faulty(input int a, input logic [DW-1:0] v);
        if (fault_en && a == fault_addr)
            return fault_sa1 ? (v | fault_mask) : (v & ~fault_mask);
        return v;
    endfunction

    always @(posedge clk) begin
        if (!csn_t_o) begin
            if (!wen_t_o) begin
                if (a_t_o != 0) rf_mem[a_t_o] <= d_t_o;
            end else begin
                rf_q <= faulty(int'(a_t_o), (a_t_o == 0) ? reg0_val : rf_mem[a_t_o]);
            end
        end
    end
    assign q_t_i = rf_q;

    // ---------------- reference model ----------------
    typedef struct {
        bit            wr;
        int            addr;
        logic [DW-1:0] data;   // write data, or expected read data
        int            elem;
    } op_t;

    op_t ops[$];

    function automatic void push_op(input bit wr, input int a, input bit ones, input int e);
        op_t o;
        o.wr   = wr;
        o.addr = a;
        o.data = ones ? '1 : '0;
        o.elem = e;
        ops.push_back(o);
    endfunction

    // March C-: E0 up(w0) E1 up(r0,w1) E2 up(r1,w0) E3 down(r0,w1) E4 down(r1,w0) E5 up(r0)
    function automatic void build_ops();
        ops.delete();
        for (int a = FIRST; a <= MAXA; a++) push_op(1, a, 0, 0);
        for (int a = FIRST; a <= MAXA; a++) begin push_op(0, a, 0, 1); push_op(1, a, 1, 1); end
        for (int a = FIRST; a <= MAXA; a++) begin push_op(0, a, 1, 2); push_op(1, a, 0, 2); end
        for (int a = MAXA; a >= FIRST; a--) begin push_op(0, a, 0, 3); push_op(1, a, 1, 3); end
        for (int a = MAXA; a >= FIRST; a--) begin push_op(0, a, 1, 4); push_op(1, a, 0, 4); end
        for (int a = FIRST; a <= MAXA; a++) push_op(0, a, 0, 5);
    endfunction

    function automatic void predict(output bit f, output int fa, output logic [DW-1:0] fd,
                                    output int fe);
        logic [DW-1:0] m [0:MAXA];
        logic [DW-1:0] v;
        f = 0; fa = 0; fd = '0; fe = 0;
        for (int i = 0; i < ops.size(); i++) begin
            if (ops[i].wr) begin
                if (ops[i].addr != 0) m[ops[i].addr] = ops[i].data;
            end else begin
                v = faulty(ops[i].addr, (ops[i].addr == 0) ? reg0_val : m[ops[i].addr]);
                if (v !== ops[i].data && !f) begin
                    f = 1; fa = ops[i].addr; fd = v; fe = ops[i].elem;
                end
            end
        end
    endfunction

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " bist"}, bist_o, 0);
        check({tag, " csn"},  csn_t_o, 1);
        check({tag, " wen"},  wen_t_o, 1);
        check({tag, " busy"}, busy_o, 0);
        check({tag, " done"}, done_o, 0);
        check({tag, " fail"}, fail_o, 0);
        check({tag, " a"},    a_t_o, 0);
        check({tag, " d"},    d_t_o, 0);
        check({tag, " faddr"}, fail_addr_o, 0);
        check({tag, " fdata"}, fail_data_o, 0);
        check({tag, " felem"}, fail_elem_o, 0);
    endtask

    // Bus view of one cycle: {csn, wen, addr when selected, data when writing}.
    function automatic logic [63:0] bus_obs();
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        a = csn_t_o ? '0 : a_t_o;
        d = (csn_t_o || wen_t_o) ? '0 : d_t_o;
        return 64'({csn_t_o, wen_t_o, a, d});
    endfunction

    function automatic logic [63:0] bus_exp(input int idx);
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        if (idx >= ops.size()) return 64'({1'b1, 1'b1, {AW{1'b0}}, {DW{1'b0}}});
        a = AW'(ops[idx].addr);
        d = ops[idx].wr ? ops[idx].data : '0;
        return 64'({1'b0, ~ops[idx].wr, a, d});
    endfunction

    // One BIST run from IDLE/DONE. repulse_at/reset_at: busy cycle index or -1.
    task automatic run_test(input string name, input int repulse_at, input int reset_at);
        bit            f;
        int            fa, fe, busy_cnt, a0_hits;
        logic [DW-1:0] fd;
        build_ops();
        predict(f, fa, fd, fe);
        @(negedge clk);
        check({name, " pre busy"}, busy_o, 0);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        check({name, " busy rise"}, busy_o, 1);
        check({name, " fail clr"},  fail_o, 0);
        check({name, " done clr"},  done_o, 0);
        busy_cnt = 0;
        a0_hits  = 0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            if (!busy_o) break;
            check({name, " op"}, bus_obs(), bus_exp(busy_cnt));
            if (!csn_t_o && a_t_o == 0) a0_hits++;
            if (busy_cnt == reset_at) begin
                rst_n = 1'b0;
                #1;
                check({name, " rst bist"}, bist_o, 0);
                check({name, " rst csn"},  csn_t_o, 1);
                check({name, " rst busy"}, busy_o, 0);
                @(negedge clk);
                check_reset_outputs({name, " rst"});
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            if (busy_cnt == repulse_at) start_i = 1'b1;
            busy_cnt++;
            @(negedge clk);
            start_i = 1'b0;
        end
        check({name, " busy len"}, busy_cnt, BUSY_LEN);
        check({name, " done"},     done_o, 1);
        check({name, " bist end"}, bist_o, 0);
        check({name, " csn end"},  csn_t_o, 1);
        check({name, " fail"},     fail_o, f);
        check({name, " addr0"},    a0_hits, 0);
`ifdef REGFILE_MBIST_DIAG_EN
        check({name, " faddr"}, fail_addr_o, fa);
        check({name, " fdata"}, fail_data_o, fd);
        check({name, " felem"}, fail_elem_o, fe);
`else
        check({name, " faddr"}, fail_addr_o, 0);
        check({name, " fdata"}, fail_data_o, 0);
        check({name, " felem"}, fail_elem_o, 0);
`endif
        // done must hold in DONE without a start
        @(negedge clk);
        check({name, " done hold"}, done_o, 1);
        check({name, " fail hold"}, fail_o, f);
    endtask

    task automatic set_fault(input bit en, input int a, input int bitn, input bit sa1);
        fault_en   = en;
        fault_addr = a;
        fault_mask = DW'(1) << bitn;
        fault_sa1  = sa1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // fault-free run
        set_fault(0, 0, 0, 0);
        run_test("clean", -1, -1);

        // stuck-at-1 at addr 7 bit 3: first caught in E1 reading 0x8
        set_fault(1, 7, 3, 1);
        run_test("sa1_a7b3", -1, -1);
        check("sa1_a7b3 fail const", fail_o, 1);
`ifdef REGFILE_MBIST_DIAG_EN
        check("sa1_a7b3 faddr const", fail_addr_o, 7);
        check("sa1_a7b3 fdata const", fail_data_o, 64'h8);
        check("sa1_a7b3 felem const", fail_elem_o, 1);
`endif

        // stuck-at-0 at addr 31 bit 0: first caught in E2 reading 0xFFFFFFFE
        set_fault(1, 31, 0, 0);
        run_test("sa0_a31b0", -1, -1);
        check("sa0_a31b0 fail const", fail_o, 1);
`ifdef REGFILE_MBIST_DIAG_EN
        check("sa0_a31b0 faddr const", fail_addr_o, 31);
        check("sa0_a31b0 fdata const", fail_data_o, 64'hFFFF_FFFE);
        check("sa0_a31b0 felem const", fail_elem_o, 2);
`endif

        // corrupted register 0 must never be read
        reg0_val = 32'hDEAD_BEEF;
        set_fault(1, 0, 5, 1);
        run_test("reg0", -1, -1);
        check("reg0 fail const", fail_o, 0);

        // start re-pulsed while busy is ignored; then restart from DONE
        set_fault(0, 0, 0, 0);
        run_test("repulse", 50, -1);
        run_test("restart", -1, -1);

        // reset mid-run, then a clean run
        run_test("midrst", -1, 100);
        run_test("after_rst", -1, -1);

        // randomized faults, gaps and re-pulses
        for (int k = 0; k < 6; k++) begin
            set_fault($urandom_range(1, 0) == 1, int'($urandom_range(MAXA, 0)),
                      int'($urandom_range(DW - 1, 0)), $urandom_range(1, 0) == 1);
            reg0_val = $urandom;
            repeat ($urandom_range(4, 0)) @(negedge clk);
            run_test($sformatf("rand%0d", k),
                     ($urandom_range(1, 0) == 1) ? int'($urandom_range(BUSY_LEN - 2, 0)) : -1,
                     -1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
